// File: rtl/stress_status_gen_pkg.sv
// Shared definitions for the SDRAM stress-test status generator:
// FSM state encodings and default blink pacing constants.
package status_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_WAIT_INIT = 2'd0;
   localparam state_t ST_SETTLE    = 2'd1;
   localparam state_t ST_RUN       = 2'd2;
   localparam state_t ST_FAIL      = 2'd3;

   // 12.5M cycles per half-period is a 2 Hz blink from a 50 MHz clock.
   localparam int BLINK_DIV_DEF  = 12500000;
   localparam int FAST_SHIFT_DEF = 2;

   function automatic logic is_display_state(input state_t s);
      return (s == ST_RUN) || (s == ST_FAIL);
   endfunction

endpackage

// File: rtl/stress_status_gen_blink_prescaler.sv
// Free-running blink prescaler: square wave at a normal or fast rate, plus a
// one-cycle rise flag that is high in the first cycle blink_speed reads 1.
module blink_prescaler
   import status_pkg::*;
#(
   parameter int BLINK_DIV  = BLINK_DIV_DEF,
   parameter int FAST_SHIFT = FAST_SHIFT_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic fast,
   input  logic restart,
   output logic blink_speed,
   output logic rise
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] LIM_NORM = CNT_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'((BLINK_DIV >> FAST_SHIFT) - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lim;
   logic             blink_q, blink_d;
   logic             rise_q, rise_d;

   assign lim = fast ? LIM_FAST : LIM_NORM;

   always_comb begin
      cnt_d   = cnt_q;
      blink_d = blink_q;
      rise_d  = 1'b0;
      // A rate change restarts the count with the level held, so the first
      // half-period at the new rate is never truncated.
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q >= lim) begin
         cnt_d   = '0;
         blink_d = ~blink_q;
         rise_d  = ~blink_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q   <= '0;
         blink_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         rise_q  <= rise_d;
      end
   end

   assign blink_speed = blink_q;
   assign rise        = rise_q;

endmodule

// File: rtl/stress_status_gen.sv
// Status generator feeding led_15seg_drv: blink pacing, display enable,
// sticky error level and a saturating mismatch counter.
module stress_status_gen
   import status_pkg::*;
#(
   parameter int BLINK_DIV      = BLINK_DIV_DEF,
   parameter int FAST_SHIFT     = FAST_SHIFT_DEF,
   parameter int SETTLE_TOGGLES = 4,
   parameter int ERR_THRESH     = 1,
   parameter int ERR_CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 init_done,
   input  logic                 cmp_valid,
   input  logic                 cmp_err,
   input  logic                 err_clr,
   output logic                 blink_speed,
   output logic                 seg_en,
   output logic                 err_det,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [1:0]           dbg_state
);

   localparam int SET_W = $clog2(SETTLE_TOGGLES + 1);
   localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_TOGGLES - 1);
   localparam logic [ERR_CNT_W-1:0] THRESH     = ERR_CNT_W'(ERR_THRESH);

   state_t                 state_q, state_d;
   logic [SET_W-1:0]       settle_q, settle_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   err_det_q, err_det_d;
   logic                   seg_en_q, seg_en_d;
   logic                   count_en;
   logic                   err_set;
   logic                   restart;
   logic                   rise;

   blink_prescaler #(
      .BLINK_DIV  (BLINK_DIV),
      .FAST_SHIFT (FAST_SHIFT)
   ) u_prescaler (
      .clk         (clk),
      .resetn      (resetn),
      .fast        (state_q == ST_FAIL),
      .restart     (restart),
      .blink_speed (blink_speed),
      .rise        (rise)
   );

   // Mismatches are only meaningful once the array is running; a clear wins
   // over a coincident mismatch.
   always_comb begin
      count_en  = is_display_state(state_q) && cmp_valid && cmp_err;
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (count_en && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
      err_det_d = err_clr ? 1'b0 : (err_det_q || (err_cnt_d >= THRESH));
      err_set   = err_det_d && !err_det_q;
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         ST_WAIT_INIT: begin
            if (init_done) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (!init_done) begin
               state_d = ST_WAIT_INIT;
            end else if (rise) begin
               settle_d = settle_q + 1'b1;
               if (settle_q == SETTLE_LAST) begin
                  state_d = err_det_q ? ST_FAIL : ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!init_done) begin
               state_d = ST_WAIT_INIT;
            end else if (err_set) begin
               state_d = ST_FAIL;
            end
         end
         ST_FAIL: begin
            if (!init_done) begin
               state_d = ST_WAIT_INIT;
            end else if (err_clr) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_WAIT_INIT;
      endcase
      restart  = (state_d == ST_FAIL) != (state_q == ST_FAIL);
      seg_en_d = is_display_state(state_d);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_WAIT_INIT;
         settle_q  <= '0;
         err_cnt_q <= '0;
         err_det_q <= 1'b0;
         seg_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         err_cnt_q <= err_cnt_d;
         err_det_q <= err_det_d;
         seg_en_q  <= seg_en_d;
      end
   end

   assign seg_en    = seg_en_q;
   assign err_det   = err_det_q;
   assign err_cnt   = err_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_stress_status_gen.sv
// Directed bench for stress_status_gen with a small blink divider so every
// phase of the status sequence fits in a few hundred cycles.
module tb_stress_status_gen;

   localparam int CW = 4;
   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_FAIL = 2'd3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          init_done = 1'b0;
   logic          cmp_valid = 1'b0;
   logic          cmp_err = 1'b0;
   logic          err_clr = 1'b0;
   logic          blink_speed;
   logic          seg_en;
   logic          err_det;
   logic [CW-1:0] err_cnt;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   stress_status_gen #(
      .BLINK_DIV      (4),
      .FAST_SHIFT     (1),
      .SETTLE_TOGGLES (2),
      .ERR_THRESH     (3),
      .ERR_CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .init_done   (init_done),
      .cmp_valid   (cmp_valid),
      .cmp_err     (cmp_err),
      .err_clr     (err_clr),
      .blink_speed (blink_speed),
      .seg_en      (seg_en),
      .err_det     (err_det),
      .err_cnt     (err_cnt),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_rises(input int n, input logic [CW-1:0] exp_cnt, input string tag);
      int   seen = 0;
      logic prev = blink_speed;
      for (int i = 0; i < 60 && seen < n; i++) begin
         tick();
         check({tag, "_seg_en_low"}, seg_en, 1'b0);
         check({tag, "_err_cnt"}, err_cnt, exp_cnt);
         if (!prev && blink_speed) seen++;
         prev = blink_speed;
      end
      check({tag, "_rises_seen"}, seen, n);
   endtask

   task automatic check_blink(input int half, input int n, input string tag);
      logic b0 = blink_speed;
      for (int k = 1; k <= n; k++) begin
         tick();
         check(tag, blink_speed, b0 ^ logic'((k / half) & 1));
      end
   endtask

   task automatic mismatch(input int cycles);
      cmp_valid = 1'b1;
      cmp_err   = 1'b1;
      repeat (cycles) tick();
      cmp_valid = 1'b0;
      cmp_err   = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_blink", blink_speed, 1'b0);
      check("rst_seg_en", seg_en, 1'b0);
      check("rst_err_det", err_det, 1'b0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_state", dbg_state, S_WAIT);
      resetn = 1'b1;

      // 1: normal-rate blink with init_done low, half-period 4
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("wait_blink", blink_speed, logic'((k / 4) & 1));
         check("wait_seg_en", seg_en, 1'b0);
      end
      check("wait_err_det", err_det, 1'b0);
      check("wait_err_cnt", err_cnt, 0);

      // 2: settle for two rises, display on one cycle later
      init_done = 1'b1;
      wait_rises(2, 0, "settle1");
      tick();
      check("run_seg_en", seg_en, 1'b1);
      check("run_state", dbg_state, S_RUN);
      cmp_valid = 1'b1;
      cmp_err   = 1'b0;
      repeat (100) tick();
      cmp_valid = 1'b0;
      check("good_cmp_err_cnt", err_cnt, 0);
      check("good_cmp_err_det", err_det, 1'b0);
      cmp_err = 1'b1;
      tick();
      check("err_without_valid", err_cnt, 0);
      cmp_err = 1'b0;

      // 3: three mismatch pulses trip err_det and the fast blink
      for (int p = 1; p <= 3; p++) begin
         mismatch(1);
         check("pulse_err_cnt", err_cnt, p);
         check("pulse_err_det", err_det, logic'(p == 3));
         check("pulse_state", dbg_state, (p == 3) ? S_FAIL : S_RUN);
         check("pulse_seg_en", seg_en, 1'b1);
         if (p < 3) tick();
      end
      check_blink(2, 8, "fail_fast_blink");
      check("fail_seg_en", seg_en, 1'b1);

      // 4: saturation, then a clear that beats a coincident mismatch
      cmp_valid = 1'b1;
      cmp_err   = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         check("sat_err_cnt", err_cnt, (3 + i > 15) ? 15 : 3 + i);
      end
      err_clr = 1'b1;
      tick();
      err_clr   = 1'b0;
      cmp_valid = 1'b0;
      cmp_err   = 1'b0;
      check("clr_err_cnt", err_cnt, 0);
      check("clr_err_det", err_det, 1'b0);
      check("clr_state", dbg_state, S_RUN);
      check_blink(4, 8, "clr_norm_blink");

      // 5: back to FAIL, lose init_done, err_det must survive
      mismatch(3);
      check("refail_err_cnt", err_cnt, 3);
      check("refail_state", dbg_state, S_FAIL);
      init_done = 1'b0;
      tick();
      check("drop_seg_en", seg_en, 1'b0);
      check("drop_err_det", err_det, 1'b1);
      check("drop_state", dbg_state, S_WAIT);

      // 6: mismatches ignored in WAIT_INIT and SETTLE
      mismatch(5);
      check("wait_mismatch_cnt", err_cnt, 3);
      cmp_valid = 1'b1;
      cmp_err   = 1'b1;
      init_done = 1'b1;
      wait_rises(2, 3, "settle2");
      cmp_valid = 1'b0;
      cmp_err   = 1'b0;
      tick();
      check("resettle_seg_en", seg_en, 1'b1);
      check("resettle_state", dbg_state, S_FAIL);
      check("resettle_err_det", err_det, 1'b1);
      check("resettle_err_cnt", err_cnt, 3);
      check_blink(2, 8, "resettle_fast_blink");

      // Async reset mid-RUN
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("run2_state", dbg_state, S_RUN);
      mismatch(1);
      check("run2_err_cnt", err_cnt, 1);
      for (int i = 0; i < 10 && !blink_speed; i++) tick();
      check("pre_rst_blink", blink_speed, 1'b1);
      check("pre_rst_seg_en", seg_en, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_blink", blink_speed, 1'b0);
      check("async_rst_seg_en", seg_en, 1'b0);
      check("async_rst_err_det", err_det, 1'b0);
      check("async_rst_err_cnt", err_cnt, 0);
      check("async_rst_state", dbg_state, S_WAIT);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stress_status_gen.md
Name: stress_status_gen

Overview:
- Upstream status stage for led_15seg_drv in the SDRAM stress-test array FPGA.
- Turns the raw compare stream and the SDRAM init flag into three signals for the LED driver:
  - blink_speed: square-wave pacing clock.
  - seg_en: display enable.
  - err_det: sticky error level.
- Also keeps a saturating mismatch counter for debug readout.

Parameters:
- BLINK_DIV, 12500000, clk cycles per blink_speed half-period at normal rate; must be >= 2^FAST_SHIFT.
- FAST_SHIFT, 2, fail-state rate: half-period becomes BLINK_DIV >> FAST_SHIFT.
- SETTLE_TOGGLES, 4, blink_speed rising edges to wait after init_done before enabling the display.
- ERR_THRESH, 1, qualified mismatches needed to assert err_det; range 1..2^ERR_CNT_W-1.
- ERR_CNT_W, 16, width of err_cnt.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, asynchronous active-low reset.
- init_done, input, 1, SDRAM init/calibration complete (level).
- cmp_valid, input, 1, compare result valid this cycle.
- cmp_err, input, 1, data mismatch; qualified by cmp_valid.
- err_clr, input, 1, single-cycle clear request.
- blink_speed, output, 1, pacing square wave to LED driver.
- seg_en, output, 1, display enable to LED driver.
- err_det, output, 1, sticky error to LED driver.
- err_cnt, output, ERR_CNT_W, saturating mismatch count.

Behaviour:
- Reset (async, resetn=0):
  - state=WAIT_INIT, prescaler=0, settle count=0.
  - blink_speed=0, seg_en=0, err_det=0, err_cnt=0.
- Clocking: all outputs registered; clock is clk; reset is asynchronous, active-low.
- Prescaler:
  - Free-runs in every state; limit L = BLINK_DIV-1, or (BLINK_DIV>>FAST_SHIFT)-1 in FAIL.
  - When the count equals L: count -> 0 and blink_speed toggles; otherwise count +1.
  - On every state change into or out of FAIL: count -> 0 and blink_speed is held, so the first half-period at the new rate is full length.
  - Internal rise pulse = blink_speed 0->1 edge, same cycle the register updates.
- FSM:
  - WAIT_INIT:
    - seg_en=0.
    - If init_done: go to SETTLE, settle count cleared.
  - SETTLE:
    - seg_en=0; settle count +1 on each rise.
    - If init_done=0: go to WAIT_INIT.
    - When the count reaches SETTLE_TOGGLES: go to RUN if err_det=0, else go to FAIL.
  - RUN:
    - seg_en=1.
    - If init_done=0: go to WAIT_INIT (seg_en=0 the next cycle).
    - Else if err_det is being set this cycle: go to FAIL.
  - FAIL:
    - seg_en=1.
    - If init_done=0: go to WAIT_INIT.
    - Else if err_clr: go to RUN.
- Error counting:
  - Counts only in RUN or FAIL; cmp_valid&&cmp_err in other states is ignored.
  - err_cnt increments by 1 and saturates at all-ones; it never wraps.
  - err_det is set the cycle after err_cnt's next value >= ERR_THRESH.
  - err_det is sticky across init_done loss; cleared only by err_clr or reset.
- err_clr:
  - Next cycle: err_cnt=0, err_det=0.
  - Has priority over a coincident mismatch, which is dropped.
  - Is ignored for FSM purposes outside FAIL; its counter clear still applies.
- cmp_err without cmp_valid: ignored.

Decomposition:
- Shared package (status_pkg):
  - State encodings: WAIT_INIT=0, SETTLE=1, RUN=2, FAIL=3.
  - Default BLINK_DIV / FAST_SHIFT constants.
- Sub-module blink_prescaler:
  - Inputs: clk, resetn, fast, restart.
  - Outputs: blink_speed, rise.
  - Parameters: BLINK_DIV, FAST_SHIFT.
- Top: FSM, settle counter, error counter, err_det.

Test Plan (BLINK_DIV=4, FAST_SHIFT=1, SETTLE_TOGGLES=2, ERR_THRESH=3, ERR_CNT_W=4):
1. Reset release with init_done=0:
   - blink_speed toggles every 4 clk (period 8).
   - seg_en stays 0.
   - err_det=0, err_cnt=0.
2. Raise init_done:
   - seg_en rises one cycle after the 2nd blink_speed rising edge post-init_done.
   - cmp_valid with cmp_err=0 for 100 cycles -> err_cnt stays 0, err_det stays 0.
3. In RUN, 3 pulses of cmp_valid&&cmp_err:
   - err_cnt=1,2,3.
   - err_det=1 the cycle after the 3rd pulse.
   - blink_speed half-period becomes 2 clk after a full-length first half.
   - seg_en stays 1.
4. 20 more mismatches:
   - err_cnt saturates at 15.
   - err_clr with a coincident mismatch -> err_cnt=0, err_det=0, state RUN, half-period back to 4.
5. Drop init_done during FAIL:
   - seg_en=0 next cycle; err_det stays 1.
   - Re-raise init_done -> after 2 rises, seg_en=1, state FAIL, fast blink.
6. Mismatches during WAIT_INIT/SETTLE -> err_cnt unchanged.
   - Assert resetn=0 mid-RUN -> all outputs 0 immediately, without waiting for a clk edge.
